// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed WIDTH x WIDTH multiplier, radix-4 modified Booth.
// Retires two multiplier bits per cycle and shares the ctrl_MULT/ctrl_DIV handshake
// with the sibling divider, so the outputs of the two units can be muxed directly.
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   data_operandA/B       multiplicand / multiplier, two's complement, sampled at start
//   ctrl_MULT, ctrl_DIV   start pulse / divide start (aborts this unit, wins over MULT)
//   data_result           low WIDTH bits of the signed product (held until next result)
//   data_exception        product does not fit in signed WIDTH bits
//   data_resultRDY        one-cycle pulse marking the result valid
module booth_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned AW    = WIDTH + 2;
    localparam int unsigned CW    = $clog2(WIDTH / 2) + 1;
    localparam int unsigned STEPS = WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    // Booth step datapath: select term from {mq[1:0], q_m1} and accumulate
    logic [AW-1:0]    m_ext_c;
    logic [AW-1:0]    term_c;
    logic             sub_c;
    logic [AW-1:0]    sum_c;
    logic [WIDTH:0]   prod_hi_c;

    always_comb begin
        m_ext_c = {{2{m_q[WIDTH-1]}}, m_q};
        term_c  = '0;
        sub_c   = 1'b0;
        unique case ({mq_q[1:0], qm1_q})
            3'b001, 3'b010: term_c = m_ext_c;
            3'b011:         term_c = m_ext_c << 1;
            3'b100: begin
                term_c = ~(m_ext_c << 1);
                sub_c  = 1'b1;
            end
            3'b101, 3'b110: begin
                term_c = ~m_ext_c;
                sub_c  = 1'b1;
            end
            default:        term_c = '0;
        endcase
        // subtraction = add inverted operand with carry-in 1; wrap is discarded
        sum_c = acc_q + term_c + AW'(sub_c);
    end

    // Overflow iff the upper product bits plus the result sign bit are not uniform
    assign prod_hi_c = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};

    // Next-state and datapath update; ctrl_DIV abort has highest priority
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        qm1_d    = qm1_q;
        count_d  = count_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (ctrl_DIV) begin
            state_d = IDLE;
        end else if (ctrl_MULT) begin
            m_d     = data_operandA;
            acc_d   = '0;
            mq_d    = data_operandB;
            qm1_d   = 1'b0;
            count_d = '0;
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    // arithmetic shift right by 2 of {sum, mq, q_m1}
                    acc_d   = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
                    mq_d    = {sum_c[1:0], mq_q[WIDTH-1:2]};
                    qm1_d   = mq_q[1];
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(STEPS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    result_d = mq_q;
                    exc_d    = ~((&prod_hi_c) | ~(|prod_hi_c));
                    rdy_d    = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            qm1_q    <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            qm1_q    <= qm1_d;
            count_q  <= count_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Testbench for booth_multiplier: directed corner cases, randomized operands checked
// against a plain signed 64-bit product, restart, abort and asynchronous reset.
module tb_booth_multiplier;

    localparam int unsigned WIDTH   = 32;
    localparam int          LATENCY = WIDTH / 2 + 1;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    int n_checks;
    int n_errors;

    booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full signed product with plain arithmetic
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    function automatic logic ref_exc(input logic [63:0] p);
        logic [31:0] lo;
        lo = p[31:0];
        return p != 64'(longint'($signed(lo)));
    endfunction

    // Pulse ctrl_MULT so it is sampled on the next rising edge; scramble operands afterwards
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Wait (bounded) for RDY, check its edge, the result and the one-cycle pulse width
    task automatic wait_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int          got;
        logic [63:0] p;
        got = 0;
        p   = ref_prod(a, b);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                got = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(got), 64'(LATENCY));
        if (got != 0) begin
            check({tag, " result"}, 64'(data_result), 64'(p[31:0]));
            check({tag, " exception"}, 64'(data_exception), 64'(ref_exc(p)));
            @(posedge clock);
            #1;
            check({tag, " rdy pulse"}, 64'(data_resultRDY), 64'd0);
        end
    endtask

    // Count RDY pulses over n edges
    task automatic count_rdy(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
    endtask

    initial begin
        logic [31:0] dir_a [5];
        logic [31:0] dir_b [5];
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;

        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        #2 reset_n = 1'b0;
        #20;
        check("reset result", 64'(data_result), 64'd0);
        check("reset exception", 64'(data_exception), 64'd0);
        check("reset rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        dir_a = '{32'd7, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000, 32'h0001_0000};
        dir_b = '{32'd6, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
        for (int i = 0; i < 5; i++) begin
            start(dir_a[i], dir_b[i]);
            wait_and_check($sformatf("dir%0d", i), dir_a[i], dir_b[i]);
        end
        // Fixed expectations for the headline corners, independent of the model
        check("7x6 literal", 64'(ref_prod(32'd7, 32'd6)), 64'h2A);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = ra >> $urandom_range(31, 16);
            if (i % 4 == 2) rb = rb >> $urandom_range(31, 16);
            start(ra, rb);
            wait_and_check($sformatf("rand%0d", i), ra, rb);
        end

        // Restart mid-run: second start sampled at edge 8
        start(32'h1234, 32'h10);
        count_rdy(7, seen);
        check("restart no early rdy", 64'(seen), 64'd0);
        start(32'd3, 32'd4);
        wait_and_check("restart", 32'd3, 32'd4);

        // Abort via ctrl_DIV at edge 5
        start(32'd9, 32'd9);
        count_rdy(4, seen);
        @(negedge clock);
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        count_rdy(40, seen);
        check("abort no rdy", 64'(seen), 64'd0);
        check("abort result held", 64'(data_result), 64'd12);

        // Asynchronous reset mid-cycle after edge 8 of a run
        start(32'd9, 32'd9);
        for (int k = 0; k < 8; k++) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset result", 64'(data_result), 64'd0);
        check("async reset exception", 64'(data_exception), 64'd0);
        check("async reset rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        count_rdy(40, seen);
        check("post reset no rdy", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
